// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared definitions for the data-RAM access unit: access size
//                codes, FSM state encoding, the latched request record, the
//                default memory size and the request legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

  // Default addressable size of the data RAM in bytes (131072 words).
  localparam int unsigned c_mem_bytes_default = 32'd524288;

  // Access size as carried on req_size.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  // Access unit FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Request fields kept for the multi-cycle part of an access. The
  // store/load direction is not kept: LOAD and MERGE already encode it.
  typedef struct packed {
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // A request is refused (error response, no RAM access) for the reserved
  // size code, a misaligned half/word, or an address past the end of RAM.
  function automatic logic req_is_bad(input size_e       size,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (addr >= mem_bytes) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bus bundle around the data-RAM access unit.
//                Request/response channel (pipeline MEM stage side):
//                  req_valid/req_ready handshake, req_we, req_size[1:0],
//                  req_uns, req_addr[31:0], req_wdata[31:0];
//                  resp_valid (1-cycle pulse), resp_err, resp_rdata[31:0].
//                Block-RAM port:
//                  ram_en, ram_we, ram_rst, ram_addr[31:0], ram_di[31:0]
//                  towards the RAM; ram_dout[31:0] back (1-cycle latency).
//                Modports: master = pipeline, slave = access unit,
//                ram = block RAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output ram_en, ram_we, ram_rst, ram_addr, ram_di,
    input  ram_dout
  );

  modport ram (
    input  ram_en, ram_we, ram_rst, ram_addr, ram_di,
    output ram_dout
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_lane_align
//  Description : Combinational byte-lane logic for the access unit.
//                Load path : picks the addressed byte/half of the RAM word
//                            (little-endian) and sign/zero extends it.
//                Store path: overlays the right-aligned store data onto the
//                            addressed lane(s) of the RAM word.
//  Ports       : i_size, i_uns, i_addr_lo[1:0], i_rdata[31:0] (RAM word),
//                i_wdata[31:0] (store data); o_load_data[31:0],
//                o_merged[31:0].
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_byte_shamt;
  logic [4:0]  w_half_shamt;
  logic [31:0] w_mask;
  logic [31:0] w_wrep;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half       = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_byte_shamt = {i_addr_lo, 3'b000};
  assign w_half_shamt = {i_addr_lo[1], 4'b0000};

  // Store data is replicated across all lanes so only the mask has to move.
  always_comb begin
    o_load_data = i_rdata;
    w_mask      = 32'hFFFF_FFFF;
    w_wrep      = i_wdata;
    case (i_size)
      SZ_B: begin
        o_load_data = {{24{~i_uns & w_byte[7]}}, w_byte};
        w_mask      = 32'h0000_00FF << w_byte_shamt;
        w_wrep      = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_load_data = {{16{~i_uns & w_half[15]}}, w_half};
        w_mask      = 32'h0000_FFFF << w_half_shamt;
        w_wrep      = {2{i_wdata[15:0]}};
      end
      default: begin
        o_load_data = i_rdata;
      end
    endcase
  end

  assign o_merged = (i_rdata & ~w_mask) | (w_wrep & w_mask);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Initiator for the core's word-wide data block RAM. Takes one
//                byte/half/word load or store at a time from the MEM stage,
//                drives the RAM port and returns a one-cycle response.
//                Sub-word stores are read-modify-write (RAM writes words only).
//  Parameters  : MEM_BYTES - addressable bytes; higher addresses are errors.
//  Ports       : clk  - clock, all state on rising edge
//                rstn - asynchronous active-low reset
//                bus  - mem_access_unit_if.slave (request/response channel
//                       and block-RAM port)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = c_mem_bytes_default
) (
  input  logic                clk,
  input  logic                rstn,
  mem_access_unit_if.slave    bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  req_t        r_req;
  req_t        w_req_in;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_bad;
  logic        w_ram_en;
  logic        w_ram_we;
  logic [31:0] w_ram_addr;
  logic [31:0] w_ram_di;
  logic        w_resp_err_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_req_in.size  = size_e'(bus.req_size);
  assign w_req_in.uns   = bus.req_uns;
  assign w_req_in.addr  = bus.req_addr;
  assign w_req_in.wdata = bus.req_wdata;

  assign w_accept = bus.req_valid & (r_state == ST_IDLE);
  assign w_bad    = req_is_bad(w_req_in.size, w_req_in.addr, MEM_BYTES);

  // Lane logic works on the latched request and the returning RAM word.
  mem_access_unit_lane_align u_lane_align (
    .i_size      (r_req.size),
    .i_uns       (r_req.uns),
    .i_addr_lo   (r_req.addr[1:0]),
    .i_rdata     (bus.ram_dout),
    .i_wdata     (r_req.wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // --------------------------------------------------------------------------
  // FSM state register, request latch and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req <= w_req_in;
      end
      // Response fields are loaded on entry to RESP and then held.
      if (w_state_nxt == ST_RESP) begin
        r_resp_err   <= w_resp_err_nxt;
        r_resp_rdata <= w_resp_rdata_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state, RAM port and response data
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_ram_en         = 1'b0;
    w_ram_we         = 1'b0;
    w_ram_addr       = {r_req.addr[31:2], 2'b00};
    w_ram_di         = 32'h0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'h0;
    case (r_state)
      ST_IDLE: begin
        // The first RAM cycle is issued straight from the request inputs.
        w_ram_addr = {bus.req_addr[31:2], 2'b00};
        if (w_accept) begin
          if (w_bad) begin
            w_resp_err_nxt = 1'b1;
            w_state_nxt    = ST_RESP;
          end else if (bus.req_we && (w_req_in.size == SZ_W)) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_di    = bus.req_wdata;
            w_state_nxt = ST_RESP;
          end else begin
            // Loads and sub-word stores both start with a word read.
            w_ram_en    = 1'b1;
            w_state_nxt = bus.req_we ? ST_MERGE : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        w_resp_rdata_nxt = w_load_data;
        w_state_nxt      = ST_RESP;
      end
      ST_MERGE: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_di    = w_merged;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. RAM strobes are gated by reset so an abandoned read-modify-write
  // cannot land its write while reset is asserted.
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.ram_en     = w_ram_en & rstn;
  assign bus.ram_we     = w_ram_we & rstn;
  assign bus.ram_rst    = 1'b0;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_di     = w_ram_di;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit paired with a
//                1-cycle-latency block RAM model. Directed vectors come from a
//                table; random traffic is checked against a byte-addressed
//                reference memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int unsigned c_mem_bytes = 524288;
  localparam int unsigned c_words     = c_mem_bytes / 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if ifc ();

  mem_access_unit #(.MEM_BYTES(c_mem_bytes)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  // --------------------------------------------------------------------------
  // Block RAM model: word-wide, one-cycle read latency
  // --------------------------------------------------------------------------
  logic [31:0] ram [0:c_words-1] = '{default: 32'h0};
  int          en_count   = 0;
  int          port_viol  = 0;
  logic [32:0] resp_q[$];

  always @(posedge clk) begin
    if (ifc.ram_en === 1'b1) begin
      en_count <= en_count + 1;
      if (ifc.ram_we === 1'b1) ram[ifc.ram_addr[18:2]] <= ifc.ram_di;
      else                     ifc.ram_dout <= ram[ifc.ram_addr[18:2]];
    end
  end

  always @(negedge clk) begin
    if (ifc.ram_rst !== 1'b0 || (ifc.ram_en === 1'b1 && ifc.ram_addr[1:0] !== 2'b00))
      port_viol <= port_viol + 1;
    if (ifc.resp_valid === 1'b1)
      resp_q.push_back({ifc.resp_err, ifc.resp_rdata});
  end

  // --------------------------------------------------------------------------
  // Reference model: flat byte memory, accesses built from individual bytes
  // --------------------------------------------------------------------------
  logic [7:0] refm [int unsigned];

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata,
                            output int lat, output int pulses);
    int n;
    n     = 1 << size;
    err   = (size == 2'd3) || (addr >= c_mem_bytes) || ((addr % n) != 0);
    rdata = 32'h0;
    if (err) begin
      lat    = 1;
      pulses = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) refm[addr + i] = wdata[8*i +: 8];
      lat    = (n == 4) ? 1 : 2;
      pulses = (n == 4) ? 1 : 2;
    end else begin
      for (int i = 0; i < n; i++) rdata = rdata | (32'(ref_rd(addr + i)) << (8 * i));
      if (!uns && n < 4 && rdata[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * n));
      lat    = 2;
      pulses = 1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int ncmp  = 0;
  int nfail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request (called ~1 time unit after a rising edge with the unit
  // idle) and check the response timing, contents and RAM activity.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input int e_pulses, input string nm);
    int lat;
    int en0;
    check($sformatf("%s.ready", nm), 32'(ifc.req_ready), 32'd1);
    en0           = en_count;
    ifc.req_valid = 1'b1;
    ifc.req_we    = we;
    ifc.req_size  = size;
    ifc.req_uns   = uns;
    ifc.req_addr  = addr;
    ifc.req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble the request inputs: only the latched copy may matter now.
    ifc.req_valid = 1'b0;
    ifc.req_we    = 1'($urandom);
    ifc.req_size  = 2'($urandom);
    ifc.req_uns   = 1'($urandom);
    ifc.req_addr  = $urandom;
    ifc.req_wdata = $urandom;
    lat = 1;
    while (ifc.resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s.resp_valid", nm), 32'(ifc.resp_valid), 32'd1);
    check($sformatf("%s.latency", nm), 32'(lat), 32'(e_lat));
    check($sformatf("%s.err", nm), 32'(ifc.resp_err), 32'(e_err));
    check($sformatf("%s.rdata", nm), ifc.resp_rdata, e_rd);
    check($sformatf("%s.ram_en_cycles", nm), 32'(en_count - en0), 32'(e_pulses));
    @(posedge clk); #1;
    check($sformatf("%s.pulse_end", nm), 32'(ifc.resp_valid), 32'd0);
    check($sformatf("%s.rdata_hold", nm), ifc.resp_rdata, e_rd);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int c_nvec = 27;
  vec_t tbl [c_nvec];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic        m_err;
    logic [31:0] m_rd;
    int          m_lat;
    int          m_pul;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    int          k;
    int          t;
    int          acc_t [3];
    int          q0;
    int          seen;
    logic        b_err [3];
    logic [31:0] b_rd  [3];
    logic [31:0] b_addr[3];
    logic [1:0]  b_size[3];
    logic        b_uns [3];

    //            we    size  uns   addr          wdata         err   rdata
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'h1122_3344};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hAABB_CCDD, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,         1'b0, 32'hFFFF_FFCC};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0201, 32'h0,         1'b0, 32'h0000_00CC};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,         1'b0, 32'hFFFF_AABB};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0,         1'b0, 32'h0000_AABB};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'hFFFF_FF55, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'h55BB_CCDD};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'hABCD_1234, 1'b0, 32'h0000_0000};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'h55BB_1234};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0000};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0000_0000};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h0008_0000, 32'h0,         1'b1, 32'h0000_0000};
    tbl[14] = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0000};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h0000_BEEF, 1'b1, 32'h0000_0000};
    tbl[17] = '{1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hCAFE_CAFE, 1'b1, 32'h0000_0000};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'h1122_3344};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 32'h0007_FFFF, 32'h0,         1'b0, 32'h0000_0000};
    tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h0007_FFFF, 32'h0000_0080, 1'b0, 32'h0000_0000};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 32'h0007_FFFF, 32'h0,         1'b0, 32'hFFFF_FF80};
    tbl[22] = '{1'b0, 2'd0, 1'b1, 32'h0007_FFFF, 32'h0,         1'b0, 32'h0000_0080};
    tbl[23] = '{1'b0, 2'd1, 1'b0, 32'h0007_FFFE, 32'h0,         1'b0, 32'hFFFF_8000};
    tbl[24] = '{1'b0, 2'd2, 1'b0, 32'h0007_FFFC, 32'h0,         1'b0, 32'h8000_0000};
    tbl[25] = '{1'b0, 2'd0, 1'b0, 32'h0008_0000, 32'h0,         1'b1, 32'h0000_0000};
    tbl[26] = '{1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,         1'b0, 32'h0000_0055};

    // ---------------- reset state (request pending must not reach the RAM)
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_size  = 2'd2;
    ifc.req_uns   = 1'b0;
    ifc.req_addr  = 32'h0000_0100;
    ifc.req_wdata = 32'h5A5A_5A5A;
    #1;
    check("reset.ram_en", 32'(ifc.ram_en), 32'd0);
    check("reset.ram_we", 32'(ifc.ram_we), 32'd0);
    check("reset.resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("reset.resp_err", 32'(ifc.resp_err), 32'd0);
    check("reset.resp_rdata", ifc.resp_rdata, 32'h0);
    check("reset.req_ready", 32'(ifc.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    rstn          = 1'b1;
    @(posedge clk); #1;
    check("reset.ram_word", ram[32'h100 >> 2], 32'h0);

    // ---------------- directed table
    for (int i = 0; i < c_nvec; i++) begin
      ref_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                 m_err, m_rd, m_lat, m_pul);
      issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_err, tbl[i].exp_rd, m_lat, m_pul, $sformatf("vec%0d", i));
    end

    // ---------------- back-to-back loads with req_valid held high
    b_addr[0] = 32'h100; b_size[0] = 2'd2; b_uns[0] = 1'b0;
    b_addr[1] = 32'h200; b_size[1] = 2'd2; b_uns[1] = 1'b0;
    b_addr[2] = 32'h201; b_size[2] = 2'd0; b_uns[2] = 1'b1;
    for (int j = 0; j < 3; j++)
      ref_access(1'b0, b_size[j], b_uns[j], b_addr[j], 32'h0, b_err[j], b_rd[j], m_lat, m_pul);
    q0            = resp_q.size();
    k             = 0;
    t             = 0;
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b0;
    ifc.req_wdata = 32'h0;
    ifc.req_addr  = b_addr[0];
    ifc.req_size  = b_size[0];
    ifc.req_uns   = b_uns[0];
    while (k < 3 && t < 30) begin
      rdy = ifc.req_ready;
      @(posedge clk); #1;
      t++;
      if (rdy) begin
        acc_t[k] = t;
        k++;
        if (k < 3) begin
          ifc.req_addr = b_addr[k];
          ifc.req_size = b_size[k];
          ifc.req_uns  = b_uns[k];
        end
      end
    end
    ifc.req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("b2b.accepts", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b.gap01", 32'(acc_t[1] - acc_t[0]), 32'd3);
      check("b2b.gap12", 32'(acc_t[2] - acc_t[1]), 32'd3);
    end
    check("b2b.resp_count", 32'(resp_q.size() - q0), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (q0 + j < resp_q.size()) begin
        check($sformatf("b2b.rdata%0d", j), resp_q[q0+j][31:0], b_rd[j]);
        check($sformatf("b2b.err%0d", j), 32'(resp_q[q0+j][32]), 32'(b_err[j]));
      end
    end

    // ---------------- reset during the merge cycle of a byte store
    ref_access(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, m_err, m_rd, m_lat, m_pul);
    issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, m_err, m_rd, m_lat, m_pul, "pre_rst_sw");
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_size  = 2'd0;
    ifc.req_uns   = 1'b0;
    ifc.req_addr  = 32'h300;
    ifc.req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    check("merge.ram_we_before_rst", 32'(ifc.ram_we), 32'd1);
    rstn = 1'b0;
    #1;
    check("merge_rst.ram_en", 32'(ifc.ram_en), 32'd0);
    check("merge_rst.ram_we", 32'(ifc.ram_we), 32'd0);
    check("merge_rst.req_ready", 32'(ifc.req_ready), 32'd1);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ifc.resp_valid !== 1'b0) seen++;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ifc.resp_valid !== 1'b0) seen++;
    end
    check("merge_rst.no_resp", 32'(seen), 32'd0);
    check("merge_rst.ram_word", ram[32'h300 >> 2], 32'hCAFE_F00D);
    check("merge_rst.req_ready_after", 32'(ifc.req_ready), 32'd1);
    ref_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, m_err, m_rd, m_lat, m_pul);
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, m_err, m_rd, m_lat, m_pul, "post_rst_lw");

    // ---------------- randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      int r;
      we    = 1'($urandom);
      uns   = 1'($urandom);
      wdata = $urandom;
      r     = int'($urandom_range(0, 15));
      size  = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      r     = int'($urandom_range(0, 19));
      if (r == 0)      addr = 32'h0008_0000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = $urandom;
      else if (r == 2) addr = 32'h0007_FFF8 + 32'($urandom_range(0, 7));
      else             addr = 32'h0000_0400 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd2)      addr[1:0] = 2'b00;
        else if (size == 2'd1) addr[0]   = 1'b0;
      end
      ref_access(we, size, uns, addr, wdata, m_err, m_rd, m_lat, m_pul);
      issue(we, size, uns, addr, wdata, m_err, m_rd, m_lat, m_pul, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    check("port_rules", 32'(port_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
